// File: rtl/ccip_host_rd_engine.sv
`default_nettype none
// ============================================================================
//  Module   : ccip_host_rd_engine
//  Purpose  : Reads a contiguous host buffer of cache lines over CCI-P
//             channel 0 and streams the returned lines out unreordered.
//             A job is a base line address plus a line count, launched by
//             a single-cycle start pulse.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             start, base_addr,
//             num_lines           - job launch and job parameters
//             c0TxAlmFull         - CCI-P c0 almost-full back-pressure
//             tx_c0_valid/addr/
//             mdata               - registered read request, tag = offset
//             rx_c0_rspValid/
//             mdata/data          - read response
//             out_valid/data/
//             index               - delivered line and its offset
//             busy, done          - job active / completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
module ccip_host_rd_engine #(
   parameter int LEN_W   = 16,  // line-count width, at most 16 (tag width)
   parameter int MAX_OUT = 32   // request-in-flight limit, power of 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [41:0]        base_addr,
   input  logic [LEN_W-1:0]   num_lines,
   input  logic               c0TxAlmFull,
   output logic               tx_c0_valid,
   output logic [41:0]        tx_c0_addr,
   output logic [15:0]        tx_c0_mdata,
   input  logic               rx_c0_rspValid,
   input  logic [15:0]        rx_c0_mdata,
   input  logic [511:0]       rx_c0_data,
   output logic               out_valid,
   output logic [511:0]       out_data,
   output logic [LEN_W-1:0]   out_index,
   output logic               busy,
   output logic               done
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_ISSUE = 2'd1;
   localparam logic [1:0] c_DRAIN = 2'd2;
   localparam logic [1:0] c_DONE  = 2'd3;

   logic [1:0]       r_state;
   logic [1:0]       w_next;
   logic [41:0]      r_base;
   logic [LEN_W-1:0] r_num;
   logic [LEN_W-1:0] r_issued;
   logic [LEN_W-1:0] r_received;
   logic             r_almfull;
   logic [LEN_W-1:0] w_outstanding;
   logic             w_room;
   logic             w_issue;
   logic             w_rsp;
   logic             w_start_acc;

   // Only a non-empty job loads the job registers; an empty one just pulses done.
   assign w_start_acc   = (r_state == c_IDLE) && start && (num_lines != '0);
   assign w_outstanding = r_issued - r_received;
   assign w_room        = 32'(w_outstanding) < 32'(MAX_OUT);
   // Almost-full is used registered, so at most one request leaks out after it rises.
   assign w_issue       = (r_state == c_ISSUE) && !r_almfull && w_room &&
                          (r_issued < r_num);
   // Responses outside an active job are stale and dropped.
   assign w_rsp         = rx_c0_rspValid &&
                          ((r_state == c_ISSUE) || (r_state == c_DRAIN));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         c_IDLE: begin
            if (start) begin
               w_next = (num_lines == '0) ? c_DONE : c_ISSUE;
            end
         end
         c_ISSUE: begin
            if (r_issued == r_num) begin
               w_next = c_DRAIN;
            end
         end
         c_DRAIN: begin
            if (r_received == r_num) begin
               w_next = c_DONE;
            end
         end
         default: w_next = c_IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (r_state)
         c_ISSUE, c_DRAIN: busy = 1'b1;
         c_DONE:           done = 1'b1;
         default: ;
      endcase
   end

   // Job registers, counters, request and response pipelines
   always_ff @(posedge clk) begin
      if (rst) begin
         r_base      <= '0;
         r_num       <= '0;
         r_issued    <= '0;
         r_received  <= '0;
         r_almfull   <= 1'b0;
         tx_c0_valid <= 1'b0;
         tx_c0_addr  <= '0;
         tx_c0_mdata <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_index   <= '0;
      end else begin
         r_almfull   <= c0TxAlmFull;
         tx_c0_valid <= w_issue;
         if (w_issue) begin
            // 42-bit add wraps silently at the top of the address space.
            tx_c0_addr  <= r_base + 42'(r_issued);
            tx_c0_mdata <= 16'(r_issued);
         end
         if (w_start_acc) begin
            r_base     <= base_addr;
            r_num      <= num_lines;
            r_issued   <= '0;
            r_received <= '0;
         end else begin
            if (w_issue) begin
               r_issued <= r_issued + LEN_W'(1);
            end
            if (w_rsp) begin
               r_received <= r_received + LEN_W'(1);
            end
         end
         out_valid <= w_rsp;
         if (w_rsp) begin
            out_data  <= rx_c0_data;
            out_index <= rx_c0_mdata[LEN_W-1:0];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ccip_host_rd_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ccip_host_rd_engine
//  Purpose  : Scoreboard bench for ccip_host_rd_engine. Expected requests are
//             queued when a job starts, expected output lines when a response
//             is driven; both are compared as the DUT produces them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ccip_host_rd_engine;

   localparam int LW = 16;
   localparam int MO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [41:0]   base_addr;
   logic [LW-1:0] num_lines;
   logic          c0TxAlmFull;
   logic          tx_c0_valid;
   logic [41:0]   tx_c0_addr;
   logic [15:0]   tx_c0_mdata;
   logic          rx_c0_rspValid;
   logic [15:0]   rx_c0_mdata;
   logic [511:0]  rx_c0_data;
   logic          out_valid;
   logic [511:0]  out_data;
   logic [LW-1:0] out_index;
   logic          busy;
   logic          done;

   ccip_host_rd_engine #(.LEN_W(LW), .MAX_OUT(MO)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .base_addr      (base_addr),
      .num_lines      (num_lines),
      .c0TxAlmFull    (c0TxAlmFull),
      .tx_c0_valid    (tx_c0_valid),
      .tx_c0_addr     (tx_c0_addr),
      .tx_c0_mdata    (tx_c0_mdata),
      .rx_c0_rspValid (rx_c0_rspValid),
      .rx_c0_mdata    (rx_c0_mdata),
      .rx_c0_data     (rx_c0_data),
      .out_valid      (out_valid),
      .out_data       (out_data),
      .out_index      (out_index),
      .busy           (busy),
      .done           (done)
   );

   always #5 clk = ~clk;

   int errs = 0;
   int chks = 0;
   int cyc  = 0;

   // request scoreboard
   logic [41:0] exq_addr[$];
   logic [15:0] exq_tag[$];
   int          exq_ptr = 0;
   // observed requests, consumed by the responder
   int          seen_tag[$];
   int          seen_cyc[$];
   int          resp_ptr = 0;
   // output scoreboard
   logic [511:0] exo_data[$];
   int           exo_idx[$];
   int           exo_due[$];
   int           exo_ptr = 0;

   int req_cnt = 0, out_cnt = 0, done_cnt = 0, done_cyc = -1, last_rsp_cyc = -1;
   bit busy_seen = 0, busy_at_done = 0, auto_en = 0;
   int salt = 0;
   int job_t, job_r0, job_d0, job_o0, job_first, job_n;

   task automatic check_eq(input string tag, input logic [511:0] got,
                           input logic [511:0] exp);
      chks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [511:0] mkdata(input int tag, input int s);
      logic [511:0] d;
      for (int j = 0; j < 16; j++) begin
         d[j*32 +: 32] = 32'(tag) * 32'h0100_0193 + 32'(j) + (32'(s) << 8);
      end
      return d;
   endfunction

   // Observe the current cycle's outputs (called at the falling edge).
   task automatic sample();
      if (tx_c0_valid) begin
         seen_tag.push_back(int'(tx_c0_mdata));
         seen_cyc.push_back(cyc);
         req_cnt++;
         if (exq_ptr < exq_addr.size()) begin
            check_eq("req_addr", tx_c0_addr, exq_addr[exq_ptr]);
            check_eq("req_mdata", tx_c0_mdata, exq_tag[exq_ptr]);
            exq_ptr++;
         end else begin
            check_eq("req_extra", tx_c0_valid, 0);
         end
      end
      if (exo_ptr < exo_due.size() && exo_due[exo_ptr] == cyc) begin
         check_eq("out_valid", out_valid, 1);
         check_eq("out_index", out_index, exo_idx[exo_ptr]);
         check_eq("out_data", out_data, exo_data[exo_ptr]);
         exo_ptr++;
      end else begin
         check_eq("out_spurious", out_valid, 0);
      end
      if (out_valid) out_cnt++;
      if (busy) busy_seen = 1;
      if (done) begin
         done_cnt++;
         done_cyc     = cyc;
         busy_at_done = busy;
      end
   endtask

   task automatic drive_rsp(input int tag, input bit acc);
      rx_c0_rspValid = 1'b1;
      rx_c0_mdata    = 16'(tag);
      rx_c0_data     = mkdata(tag, salt);
      last_rsp_cyc   = cyc;
      if (acc) begin
         exo_idx.push_back(tag);
         exo_data.push_back(mkdata(tag, salt));
         exo_due.push_back(cyc + 1);
      end
   endtask

   // One clock: sample outputs mid-cycle, then advance and drive new inputs.
   task automatic step();
      @(negedge clk);
      sample();
      @(posedge clk);
      cyc++;
      #1;
      rx_c0_rspValid = 1'b0;
      start          = 1'b0;
      if (auto_en && resp_ptr < seen_cyc.size() && seen_cyc[resp_ptr] + 2 <= cyc) begin
         drive_rsp(seen_tag[resp_ptr], 1'b1);
         resp_ptr++;
      end
   endtask

   task automatic start_job(input logic [41:0] base, input int n);
      job_r0    = req_cnt;
      job_d0    = done_cnt;
      job_o0    = out_cnt;
      job_first = seen_cyc.size();
      job_n     = n;
      busy_seen = 0;
      salt++;
      for (int i = 0; i < n; i++) begin
         exq_addr.push_back(base + 42'(i));
         exq_tag.push_back(16'(i));
      end
      base_addr = base;
      num_lines = LW'(n);
      start     = 1'b1;
      job_t     = cyc;
      step();
      if (n == 0) begin
         check_eq("zl_done_t1", done, 1);
         check_eq("zl_busy_t1", busy, 0);
      end else begin
         check_eq("start_busy", busy, 1);
      end
   endtask

   task automatic finish_job(input bit poke);
      int k = 0;
      while (done_cnt == job_d0 && k < 3000) begin
         if (poke && k == 3) begin
            start     = 1'b1;
            base_addr = 42'h155;
            num_lines = LW'(2);
         end
         step();
         k++;
      end
      check_eq("done_seen", done_cnt != job_d0, 1);
      if (job_n == 0) begin
         check_eq("zl_done_cyc", done_cyc, job_t + 1);
         check_eq("zl_busy_never", busy_seen, 0);
      end else begin
         check_eq("done_cyc", done_cyc, last_rsp_cyc + 2);
         check_eq("done_busy", busy_at_done, 0);
         if (seen_cyc.size() > job_first)
            check_eq("first_req_cyc", seen_cyc[job_first], job_t + 2);
      end
      check_eq("req_total", req_cnt - job_r0, job_n);
      check_eq("out_total", out_cnt - job_o0, job_n);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int a, f, nbp, nres, k;
      int ord[4] = '{3, 1, 0, 2};
      rst = 1'b1; start = 1'b0; base_addr = '0; num_lines = '0;
      c0TxAlmFull = 1'b0; rx_c0_rspValid = 1'b0; rx_c0_mdata = '0; rx_c0_data = '0;
      repeat (3) step();
      check_eq("rst_tx_valid", tx_c0_valid, 0);
      check_eq("rst_tx_addr", tx_c0_addr, 0);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      rst = 1'b0;
      step();

      // basic in-order job
      auto_en = 1;
      start_job(42'h1000, 4);
      finish_job(0);

      // throttled at MAX_OUT, then out-of-order returns
      auto_en = 0;
      start_job(42'h2_0000, 8);
      repeat (10) step();
      check_eq("throttle_cnt", req_cnt - job_r0, MO);
      for (int i = 0; i < 4; i++) begin
         drive_rsp(ord[i], 1'b1);
         step();
      end
      resp_ptr = job_first + 4;
      auto_en  = 1;
      finish_job(0);

      // back-pressure held for 10 cycles mid-job
      start_job(42'h3_0000, 16);
      repeat (5) step();
      a = cyc;
      c0TxAlmFull = 1'b1;
      repeat (10) step();
      f = cyc;
      c0TxAlmFull = 1'b0;
      repeat (4) step();
      nbp = 0; nres = 0;
      for (int i = job_first; i < seen_cyc.size(); i++) begin
         if (seen_cyc[i] >= a + 2 && seen_cyc[i] <= f + 1) nbp++;
         if (seen_cyc[i] >= f && seen_cyc[i] <= f + 2) nres++;
      end
      check_eq("bp_none_after_one", nbp, 0);
      check_eq("bp_resume", nres > 0, 1);
      finish_job(0);

      // address wrap and zero-length job
      start_job(42'h3FF_FFFF_FFFE, 3);
      finish_job(0);
      start_job(42'h5000, 0);
      finish_job(0);

      // reset mid-job with requests outstanding
      auto_en = 0;
      start_job(42'h7000, 8);
      k = 0;
      while (req_cnt - job_r0 < 3 && k < 50) begin
         step();
         k++;
      end
      check_eq("pre_rst_reqs", req_cnt - job_r0 >= 3, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_eq("mid_rst_tx_valid", tx_c0_valid, 0);
      check_eq("mid_rst_tx_addr", tx_c0_addr, 0);
      check_eq("mid_rst_tx_mdata", tx_c0_mdata, 0);
      check_eq("mid_rst_out_valid", out_valid, 0);
      check_eq("mid_rst_out_data", out_data, 0);
      check_eq("mid_rst_out_index", out_index, 0);
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_done", done, 0);
      exq_ptr  = exq_addr.size();
      resp_ptr = seen_cyc.size();
      for (int i = 0; i < 3; i++) begin
         drive_rsp(i, 1'b0);
         step();
      end
      repeat (3) step();
      check_eq("post_rst_busy", busy, 0);

      // clean job afterwards, with a start pulse while busy
      auto_en = 1;
      start_job(42'h9000, 5);
      finish_job(1);
      repeat (3) step();

      $display("Result: errors=%0d of %0d checks", errs, chks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ccip_host_rd_engine.md
# ccip_host_rd_engine

Initiator-side companion to the MMIO responder. The block issues CCI-P channel-0 memory read requests for a contiguous host buffer of cache lines and returns the read data on a simple streaming output. Software programs the buffer address and length through MMIO, then pulses `start`. The block sits between the AFU's MMIO register file and the user datapath, and drives the Tx c0 request fields of the CCI-P interface.

## Interface

**Parameters**
- `LEN_W`, default 16: width of the line count; a single job reads at most 2^LEN_W-1 lines.
- `MAX_OUT`, default 32: maximum number of read requests in flight. Must be a power of 2 and ≤ 2^16.

**Ports**
- `clk`, in, 1: the only clock.
- `rst`, in, 1: reset, synchronous and active-high.
- `start`, in, 1: single-cycle job launch pulse.
- `base_addr`, in, 42: cache-line address of the first line; sampled when `start` is accepted.
- `num_lines`, in, LEN_W: number of lines to read; sampled when `start` is accepted.
- `c0TxAlmFull`, in, 1: CCI-P c0 almost-full back-pressure.
- `tx_c0_valid`, out, 1: read request valid (registered).
- `tx_c0_addr`, out, 42: request cache-line address.
- `tx_c0_mdata`, out, 16: request tag, equal to the line offset within the job.
- `rx_c0_rspValid`, in, 1: memory read response valid.
- `rx_c0_mdata`, in, 16: tag of the response.
- `rx_c0_data`, in, 512: response line data.
- `out_valid`, out, 1: one line delivered.
- `out_data`, out, 512: the delivered line.
- `out_index`, out, LEN_W: line offset of `out_data`.
- `busy`, out, 1: a job is active.
- `done`, out, 1: single-cycle job-complete pulse.

## Operation

**States**
- `IDLE`: accepts `start`.
  - `start` with `num_lines`=0 goes to `DONE`.
  - `start` with `num_lines`>0 latches `base_addr`/`num_lines`, clears counters and goes to `ISSUE`.
- `ISSUE`: issues requests. Moves to `DRAIN` when `issued == num_lines`.
- `DRAIN`: waits for the remaining responses. Moves to `DONE` when `received == num_lines`.
- `DONE`: pulses `done` for one cycle, then returns to `IDLE`.

**Counters**
- `issued` and `received` are LEN_W bits wide.
- `outstanding = issued - received`.

**Issue rule**
- A request is issued in a cycle when all of the following hold: state is `ISSUE`, `c0TxAlmFull`=0, `outstanding < MAX_OUT`, and `issued < num_lines`.
- Each request carries `tx_c0_addr = base + issued`, computed modulo 2^42 (wraps silently).
- Each request carries `tx_c0_mdata = issued`, zero-extended to 16 bits.
- At most one request is issued per cycle.

**Responses**
- Responses may return in any order. Each is forwarded unreordered, with `out_index = rx_c0_mdata[LEN_W-1:0]`.
- Every response counts toward `received`. A response in `ISSUE` and the issue of a request may occur in the same cycle; both counters update.
- A response that arrives while the block is in `IDLE` or `DONE` is dropped: no `out_valid`, no counter change.

**Other rules**
- `start` while `busy`=1 is ignored.
- Tags are not validated; duplicate or out-of-range tags are forwarded as received.
- `rst` in any state returns the block to `IDLE` on that edge. Counters clear, the job is abandoned, and late responses are dropped per the rule above.

## Timing

**Reset values**
- `tx_c0_valid`, `out_valid`, `busy` and `done` are 0.
- `tx_c0_addr`, `tx_c0_mdata`, `out_data` and `out_index` are 0.

**Job start**
- `start` accepted at cycle t: `busy`=1 from t+1.
- The earliest `tx_c0_valid` is at t+2.
- `num_lines`=0 is the exception: `done`=1 at t+1, and `busy` stays 0.

**Request issue**
- Request outputs are registered. An issue decision at cycle c appears on `tx_c0_*` at c+1.
- `tx_c0_valid` is high for exactly one cycle per request, and at most one request is presented per cycle.
- `c0TxAlmFull` is sampled registered. At most 1 request is emitted after it rises, which is within the CCI-P 8-request allowance.

**Response path**
- `rx_c0_rspValid` at cycle r produces `out_valid` at r+1, with data and index registered.
- Latency is fixed at 1 cycle, and the output has no back-pressure.

**Completion**
- Final response at cycle r: `out_valid` at r+1, `done`=1 at r+2.
- `busy` is 0 from r+2.
- A new `start` is accepted from r+3.

**Throughput**
- One request per cycle when not back-pressured and `outstanding < MAX_OUT`.

## Test plan

1. **Basic 4-line job.** `base_addr`=0x1000, `num_lines`=4, in-order responses 2 cycles after each request. Required:
   - requests to 0x1000–0x1003 with mdata 0–3;
   - 4 `out_valid` with index 0–3;
   - `done` exactly 2 cycles after the last response.
2. **Out-of-order and throttled.** `num_lines`=8, `MAX_OUT`=4, responses withheld. Required:
   - exactly 4 requests are issued, then issue stalls;
   - returning tags in the order 3,1,0,2 produces `out_index` 3,1,0,2, each 1 cycle after its response;
   - issue resumes, and all 8 lines complete.
3. **Back-pressure.** `c0TxAlmFull` is held high from mid-job for 10 cycles. Required:
   - at most 1 request appears after it rises and none thereafter;
   - issue resumes within 2 cycles of it falling;
   - the total request count equals `num_lines`.
4. **Wrap and zero length.**
   - `base_addr`=0x3FF_FFFF_FFFE with `num_lines`=3 produces addresses 0x3FF_FFFF_FFFE, 0x3FF_FFFF_FFFF, 0x0.
   - `num_lines`=0 produces `done` at t+1, with no `tx_c0_valid` and `busy` never set.
5. **Reset mid-job and ignored inputs.**
   - `rst` asserted with 3 requests outstanding: all outputs are 0 the next cycle, and subsequent responses produce no `out_valid`.
   - A new job then runs cleanly.
   - `start` pulsed while `busy` has no effect on the running job.
